park_button_conditioner: RTL

Input-conditioning stage that sits directly upstream of the parking-slot state machine. It takes the two raw, bouncing, asynchronous push-buttons (reserve and release) and synchronises and debounces them. It delivers clean single-cycle command pulses that the slot controller consumes as its reserve and reset commands. Release requires a deliberate long press, so a brushed button cannot clear an occupied slot.

---
 rtl/park_pkg.sv | 15 +
 rtl/park_debounce.sv | 54 +++++
 rtl/park_button_conditioner.sv | 132 +++++++++++++
 3 files changed

// File: rtl/park_pkg.sv
// Shared timing helper and release-FSM state encoding for the parking-slot input path.
// Used by park_button_conditioner (PARK_BTN_LONGPRESS_EN selects long-press release) and the slot controller.
package park_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLDING = 2'd1,
    FIRED   = 2'd2
  } rel_state_e;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    return clk_hz / 32'd1000 * ms;
  endfunction

endpackage

// File: rtl/park_debounce.sv
// Two-flop synchroniser followed by a saturating-counter debouncer for one raw push-button.
module park_debounce
  import park_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  output logic level_out
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised input disagrees with the accepted level.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_out = level_q;

endmodule

// File: rtl/park_button_conditioner.sv
// Debounced reserve/release command pulses for the parking-slot controller.
// PARK_BTN_LONGPRESS_EN: release needs a long press (HOLD_MS); otherwise it fires like reserve.
module park_button_conditioner
  import park_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 27_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned HOLD_MS     = 2000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reserve_btn_raw,
  input  logic release_btn_raw,
  output logic reserve_pulse,
  output logic release_pulse,
  output logic reserve_level,
  output logic release_armed
);

  localparam int unsigned DB_CYCLES   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned HOLD_CYCLES = ms_to_cycles(CLK_HZ, HOLD_MS);

  if (DB_CYCLES == 0 || HOLD_CYCLES == 0) begin : g_cfg_check
    $error("park_button_conditioner: debounce and hold times must be at least one cycle");
  end

  logic rsv_level, rel_level, rsv_rise, rel_rise, lockout;
  logic rsv_prev_q, rsv_prev_d, rel_prev_q, rel_prev_d;
  logic rsv_pulse_q, rsv_pulse_d, rel_pulse_q, rel_pulse_d;
  logic armed_q, armed_d;

  park_debounce #(.DB_CYCLES(DB_CYCLES)) u_rsv_db (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_in   (reserve_btn_raw),
    .level_out(rsv_level)
  );

  park_debounce #(.DB_CYCLES(DB_CYCLES)) u_rel_db (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_in   (release_btn_raw),
    .level_out(rel_level)
  );

  assign rsv_rise = rsv_level & ~rsv_prev_q;
  assign rel_rise = rel_level & ~rel_prev_q;

`ifdef PARK_BTN_LONGPRESS_EN
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  rel_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Letting go wins over reaching the hold target in the same cycle.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    rel_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rel_rise) begin
          state_d = HOLDING;
          hold_d  = '0;
        end
      end
      HOLDING: begin
        if (!rel_level) begin
          state_d = IDLE;
        end else if (hold_q >= HOLD_LAST) begin
          state_d     = FIRED;
          rel_pulse_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      FIRED: begin
        if (!rel_level) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    lockout = (state_d != IDLE);
    armed_d = (state_d == HOLDING);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end
`else
  always_comb begin
    rel_pulse_d = rel_rise;
    lockout     = rel_level;
    armed_d     = 1'b0;
  end
`endif

  // Reserve is dropped, not deferred, when locked out or colliding with release.
  always_comb begin
    rsv_prev_d  = rsv_level;
    rel_prev_d  = rel_level;
    rsv_pulse_d = rsv_rise & ~lockout & ~rel_pulse_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsv_prev_q  <= 1'b0;
      rel_prev_q  <= 1'b0;
      rsv_pulse_q <= 1'b0;
      rel_pulse_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      rsv_prev_q  <= rsv_prev_d;
      rel_prev_q  <= rel_prev_d;
      rsv_pulse_q <= rsv_pulse_d;
      rel_pulse_q <= rel_pulse_d;
      armed_q     <= armed_d;
    end
  end

  assign reserve_pulse = rsv_pulse_q;
  assign release_pulse = rel_pulse_q;
  assign reserve_level = rsv_level;
  assign release_armed = armed_q;

endmodule
